// File: rtl/ysyx_23060251_pkg.sv
// ysyx_23060251_pkg: shared widths, IFU state encoding, NOP and reset-PC constants.
package ysyx_23060251_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  typedef enum logic [1:0] {S_REQ, S_RSP, S_OUT} ifu_state_e;
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: fetch PC register; a redirect outranks the sequential +4 advance.
module ifu_pc_reg
  import ysyx_23060251_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o
);
  logic [XLEN-1:0] pc_q, pc_d;
  always_comb pc_d = redirect_i ? redirect_pc_i : advance_i ? pc_q + XLEN'(4) : pc_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch FSM (request, response, present) with redirect handling.
module ifu
  import ysyx_23060251_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] araddr_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  input  logic [ILEN-1:0] rdata_i,
  input  logic            rvalid_i,
  output logic            rready_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i
);
  ifu_state_e      state_q, state_d;
  logic            drop_q, drop_d, run_q, load_out;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] pc_out_q, pc;
  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .redirect_i   (redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .advance_i    (state_q == S_OUT && inst_ready_i),
    .pc_o         (pc)
  );
  // run_q holds off the first request until one edge after reset release
  assign arvalid_o    = run_q && state_q == S_REQ;
  assign rready_o     = state_q == S_RSP;
  assign inst_valid_o = state_q == S_OUT;
  assign araddr_o     = pc;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    load_out = 1'b0;
    case (state_q)
      S_REQ:
        if (arvalid_o && arready_i) begin
          state_d = S_RSP;
          drop_d  = redirect_valid_i;
        end
      S_RSP:
        if (redirect_valid_i) begin
          state_d = rvalid_i ? S_REQ : S_RSP;
          drop_d  = !rvalid_i;
        end else if (rvalid_i) begin
          state_d  = drop_q ? S_REQ : S_OUT;
          load_out = !drop_q;
          drop_d   = 1'b0;
        end
      S_OUT: state_d = (redirect_valid_i || inst_ready_i) ? S_REQ : S_OUT;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q  <= S_REQ;
      drop_q   <= 1'b0;
      run_q    <= 1'b0;
      inst_q   <= NOP;
      pc_out_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      run_q   <= 1'b1;
      if (load_out) begin
        inst_q   <= rdata_i;
        pc_out_q <= pc;
      end
    end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed checks of the fetch FSM plus a randomized in-order stream against a PC scoreboard.
module tb_ifu;
  logic        clk, rst_i, arvalid_o, arready_i, rvalid_i, rready_o;
  logic        redirect_valid_i, inst_valid_o, inst_ready_i;
  logic [31:0] araddr_o, rdata_i, redirect_pc_i, inst_o, pc_o;
  int          n_vec, n_err, got, cyc, dly;
  logic [31:0] exp_pc, req_addr;

  ifu dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .araddr_o        (araddr_o),
    .arvalid_o       (arvalid_o),
    .arready_i       (arready_i),
    .rdata_i         (rdata_i),
    .rvalid_i        (rvalid_i),
    .rready_o        (rready_o),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    arready_i = 0; rvalid_i = 0; rdata_i = 0; inst_ready_i = 0;
    redirect_valid_i = 0; redirect_pc_i = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clear_in();
    rst_i = 1;
    #1 rst_i = 0;
    #1;
    chk("rst_arvalid", 32'(arvalid_o), 0);
    chk("rst_rready", 32'(rready_o), 0);
    chk("rst_ivalid", 32'(inst_valid_o), 0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 0);
    @(negedge clk) rst_i = 1;
    #1 chk("pre_first_edge_arvalid", 32'(arvalid_o), 0);
    tick();
    chk("first_arvalid", 32'(arvalid_o), 1);
    chk("first_araddr", araddr_o, 32'h8000_0000);
    // basic fetch, ready decode
    arready_i = 1;
    tick();
    chk("rsp_rready", 32'(rready_o), 1);
    chk("rsp_arvalid", 32'(arvalid_o), 0);
    arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_0093; inst_ready_i = 1;
    tick();
    chk("out_valid", 32'(inst_valid_o), 1);
    chk("out_inst", inst_o, 32'h0000_0093);
    chk("out_pc", pc_o, 32'h8000_0000);
    rvalid_i = 0;
    tick();
    chk("next_araddr", araddr_o, 32'h8000_0004);
    chk("next_arvalid", 32'(arvalid_o), 1);
    // decode stall
    inst_ready_i = 0; arready_i = 1;
    tick();
    arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_AAAA;
    tick();
    rvalid_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst", inst_o, 32'h0000_AAAA);
      chk("stall_pc", pc_o, 32'h8000_0004);
      chk("stall_valid", 32'(inst_valid_o), 1);
      chk("stall_arvalid", 32'(arvalid_o), 0);
      tick();
    end
    inst_ready_i = 1;
    tick();
    inst_ready_i = 0;
    chk("stall_release_araddr", araddr_o, 32'h8000_0008);
    // redirect in RSP, response arrives later
    arready_i = 1;
    tick();
    arready_i = 0; redirect_valid_i = 1; redirect_pc_i = 32'h8000_1000;
    tick();
    redirect_valid_i = 0; rvalid_i = 1; rdata_i = 32'hDEAD_BEEF;
    tick();
    rvalid_i = 0;
    chk("rsp_redir_dropped", 32'(inst_valid_o), 0);
    chk("rsp_redir_arvalid", 32'(arvalid_o), 1);
    chk("rsp_redir_araddr", araddr_o, 32'h8000_1000);
    // redirect in RSP coincident with rvalid
    arready_i = 1;
    tick();
    arready_i = 0; redirect_valid_i = 1; redirect_pc_i = 32'h8000_2000; rvalid_i = 1;
    tick();
    redirect_valid_i = 0; rvalid_i = 0;
    chk("rsp_redir_same_valid", 32'(inst_valid_o), 0);
    chk("rsp_redir_same_araddr", araddr_o, 32'h8000_2000);
    chk("rsp_redir_same_arvalid", 32'(arvalid_o), 1);
    // redirect in OUT with decode not ready
    arready_i = 1;
    tick();
    arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_0111;
    tick();
    rvalid_i = 0;
    chk("out2_pc", pc_o, 32'h8000_2000);
    redirect_valid_i = 1; redirect_pc_i = 32'h8000_3000;
    tick();
    redirect_valid_i = 0;
    chk("out_redir_valid", 32'(inst_valid_o), 0);
    chk("out_redir_araddr", araddr_o, 32'h8000_3000);
    // redirect in REQ without handshake, then wrap
    redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 0;
    chk("req_redir_araddr", araddr_o, 32'hFFFF_FFFC);
    chk("req_redir_arvalid", 32'(arvalid_o), 1);
    arready_i = 1;
    tick();
    arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_0222;
    tick();
    rvalid_i = 0; inst_ready_i = 1;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    inst_ready_i = 0;
    chk("wrap_araddr", araddr_o, 32'h0000_0000);
    // redirect in REQ with handshake: returned word is dropped
    redirect_valid_i = 1; redirect_pc_i = 32'h8000_4000; arready_i = 1;
    tick();
    redirect_valid_i = 0; arready_i = 0;
    chk("req_redir_hs_rready", 32'(rready_o), 1);
    rvalid_i = 1; rdata_i = 32'h0000_0333;
    tick();
    rvalid_i = 0;
    chk("req_redir_hs_valid", 32'(inst_valid_o), 0);
    chk("req_redir_hs_araddr", araddr_o, 32'h8000_4000);
    // reset mid-transaction with a late response
    arready_i = 1;
    tick();
    arready_i = 0;
    rst_i = 0;
    #1;
    chk("midrst_arvalid", 32'(arvalid_o), 0);
    chk("midrst_rready", 32'(rready_o), 0);
    chk("midrst_ivalid", 32'(inst_valid_o), 0);
    chk("midrst_inst", inst_o, 32'h0000_0013);
    rvalid_i = 1; rdata_i = 32'h0BAD_0BAD;
    tick();
    @(negedge clk) rst_i = 1;
    tick();
    chk("postrst_arvalid", 32'(arvalid_o), 1);
    chk("postrst_araddr", araddr_o, 32'h8000_0000);
    chk("postrst_rready", 32'(rready_o), 0);
    tick();
    rvalid_i = 0;
    chk("postrst_late_ivalid", 32'(inst_valid_o), 0);
    chk("postrst_late_inst", inst_o, 32'h0000_0013);
    // randomized stream
    clear_in();
    rst_i = 0;
    #1;
    @(negedge clk) rst_i = 1;
    got = 0; cyc = 0; dly = -1; req_addr = 0; exp_pc = 32'h8000_0000;
    while (got < 1000 && cyc < 40000) begin
      arready_i = ($urandom_range(0, 9) < 3);
      rvalid_i = rready_o && dly == 0;
      rdata_i = ~req_addr;
      inst_ready_i = ($urandom_range(0, 9) < 7);
      if (inst_valid_o && inst_ready_i) begin
        chk("rand_pc", pc_o, exp_pc);
        chk("rand_inst", inst_o, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      if (arvalid_o && arready_i) begin
        req_addr = araddr_o;
        dly = $urandom_range(0, 4);
      end else if (rready_o && dly > 0) dly--;
      tick();
      cyc++;
    end
    chk("rand_count", 32'(got), 32'd1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 araddr_o  output  32  fetch address to instruction memory.
REQ-005 arvalid_o  output  1  fetch request valid.
REQ-006 arready_i  input  1  memory accepts the request.
REQ-007 rdata_i  input  32  returned instruction word.
REQ-008 rvalid_i  input  1  response valid.
REQ-009 rready_o  output  1  IFU accepts the response.
REQ-010 redirect_valid_i  input  1  branch/jump/trap redirect from the back end.
REQ-011 redirect_pc_i  input  32  redirect target.
REQ-012 inst_o  output  32  instruction to decode.
REQ-013 pc_o  output  32  PC of inst_o.
REQ-014 inst_valid_o  output  1  inst_o/pc_o valid.
REQ-015 inst_ready_i  input  1  decode accepts the instruction.

Function
REQ-016 FSM states SHALL be: REQ (arvalid_o=1), RSP (rready_o=1), OUT (inst_valid_o=1).
REQ-017 REQ -> RSP SHALL occur on arvalid_o&&arready_i; araddr_o SHALL equal the pc register and stay stable while arvalid_o=1.
REQ-018 RSP -> OUT SHALL occur on rvalid_i; rdata_i SHALL be latched into inst_o, and the fetch PC into pc_o, in the same edge.
REQ-019 OUT -> REQ SHALL occur on inst_ready_i; pc SHALL advance by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-020 inst_o/pc_o SHALL stay stable while inst_valid_o=1 and inst_ready_i=0.
REQ-021 redirect_valid_i in REQ: pc SHALL load redirect_pc_i.
  - If arready_i is low that cycle, the FSM SHALL stay in REQ with the new address.
  - If the handshake completes that same cycle, the FSM SHALL go to RSP with the drop flag set.
REQ-022 redirect_valid_i in RSP: pc SHALL load redirect_pc_i and a drop flag SHALL be set.
  - The next rvalid_i SHALL be consumed, not presented, and the FSM SHALL return to REQ.
  - If rvalid_i arrives in the redirect cycle itself, it SHALL be dropped and the FSM SHALL go straight to REQ.
REQ-023 redirect_valid_i in OUT: pc SHALL load redirect_pc_i and the FSM SHALL go to REQ; inst_valid_o SHALL drop next cycle regardless of inst_ready_i.
REQ-024 redirect_valid_i SHALL take priority over the +4 advance when both occur in the same cycle.
REQ-025 Latency SHALL be: request issued 1 cycle after reset release; inst_valid_o asserted 1 cycle after rvalid_i.
  - Zero-wait memory with ready decode: one instruction per 3 cycles.
REQ-026 At most one request SHALL be outstanding; rready_o SHALL be 1 only in RSP.

Reset
REQ-027 While rst_i=0, and independent of clk_i:
  - state=REQ, pc=RESET_PC, drop flag=0.
  - arvalid_o=0, rready_o=0, inst_valid_o=0.
  - inst_o=32'h0000_0013 (NOP), pc_o=0.
REQ-028 arvalid_o SHALL first assert on the first rising edge after rst_i returns to 1.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; a late rvalid_i after reset release SHALL be ignored because rready_o=0 outside RSP.

Structure
REQ-030 The ysyx_23060251 shared package SHALL hold:
  - the pc/inst bus widths;
  - the FSM state enum;
  - the NOP encoding;
  - the RESET_PC default.
REQ-031 One sub-module, ifu_pc_reg, SHALL hold the pc register with its reset, redirect and +4 logic; the FSM, drop flag and output registers SHALL stay in ifu.

Verification
REQ-032 Reset release, arready_i=1, rvalid_i one cycle after request with rdata_i=32'h00000093, inst_ready_i=1 -> araddr_o=80000000; inst_o=00000093, pc_o=80000000; next araddr_o=80000004.
REQ-033 inst_ready_i held 0 for 5 cycles in OUT -> inst_o/pc_o stable; no new arvalid_o until acceptance.
REQ-034 redirect_valid_i=1, redirect_pc_i=80001000 while in RSP -> returned word is not presented; next araddr_o=80001000.
REQ-035 pc=FFFFFFFC fetched and accepted -> next araddr_o=00000000.
REQ-036 rst_i pulled low in RSP, then a late rvalid_i arrives -> all valids 0 immediately; late response ignored; first fetch after release at 80000000.
REQ-037 arready_i random 30% and rvalid_i delay random 0-4 cycles over 1000 instructions -> pc_o strictly sequential; no duplicated or lost instruction.
